// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers a whole payload, then emits
// header, payload and XOR parity with busy back-pressure and an inter-frame gap.
//
// state   | meaning
// IDLE    | waiting for start; rejects bad requests with cfg_err
// LOAD    | taking payload bytes from the client into the buffer
// HEADER  | header beat on tx_data, waiting for busy==0
// PAYLOAD | payload beats buf[0..len-1]
// PARITY  | parity byte on tx_data with pkt_valid=0
// GAP     | forced idle cycles before the next request
module router_pkt_tx #(
  parameter int IFG_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  output logic       req_ready,
  output logic       cfg_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] tx_data,
  output logic       pkt_valid,
  output logic       pkt_done
);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam int         GW        = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

  state_t          state, state_nxt;
  logic [5:0]      len_q, len_nxt;
  logic [1:0]      addr_q, addr_nxt;
  logic [5:0]      cnt_q, cnt_nxt;
  logic [7:0]      parity_q, parity_nxt;
  logic [GW-1:0]   gap_q, gap_nxt;
  logic [7:0]      tx_nxt;
  logic            valid_nxt, done_nxt, err_nxt;
  logic            buf_we;
  logic [7:0]      buf_mem [MAX_LEN];

  assign req_ready = (state == IDLE);
  assign pl_ready  = (state == LOAD);

  always_comb begin
    state_nxt  = state;
    len_nxt    = len_q;
    addr_nxt   = addr_q;
    cnt_nxt    = cnt_q;
    parity_nxt = parity_q;
    gap_nxt    = gap_q;
    tx_nxt     = tx_data;
    valid_nxt  = pkt_valid;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    buf_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (dest_addr == 2'd3 || payload_len == 6'd0 || {1'b0, payload_len} > MAX_LEN_W) begin
            err_nxt = 1'b1;
          end else begin
            len_nxt    = payload_len;
            addr_nxt   = dest_addr;
            parity_nxt = {payload_len, dest_addr};
            cnt_nxt    = 6'd0;
            state_nxt  = LOAD;
          end
        end
      end
      LOAD: begin
        if (pl_valid) begin
          buf_we     = 1'b1;
          parity_nxt = parity_q ^ pl_data;
          cnt_nxt    = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) begin
            state_nxt = HEADER;
            tx_nxt    = {len_q, addr_q};
            valid_nxt = 1'b1;
            cnt_nxt   = 6'd0;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          state_nxt = PAYLOAD;
          tx_nxt    = buf_mem[0];
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (cnt_q == len_q - 6'd1) begin
            state_nxt = PARITY;
            tx_nxt    = parity_q;
            valid_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_q + 6'd1;
            tx_nxt  = buf_mem[cnt_nxt];
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          done_nxt = 1'b1;
          tx_nxt   = 8'd0;
          if (IFG_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GW'(IFG_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_nxt = IDLE;
        else gap_nxt = gap_q - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      parity_q  <= '0;
      gap_q     <= '0;
      tx_data   <= '0;
      pkt_valid <= 1'b0;
      pkt_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      addr_q    <= addr_nxt;
      cnt_q     <= cnt_nxt;
      parity_q  <= parity_nxt;
      gap_q     <= gap_nxt;
      tx_data   <= tx_nxt;
      pkt_valid <= valid_nxt;
      pkt_done  <= done_nxt;
      cfg_err   <= err_nxt;
    end
  end

  // Payload storage needs no reset: every byte is written before it is read.
  always_ff @(posedge clock) begin
    if (buf_we) buf_mem[cnt_q] <= pl_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: full packets, back-pressure, rejected
// requests, loading gaps, mid-packet reset and back-to-back requests.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       req_ready;
  logic       cfg_err;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] tx_data;
  logic       pkt_valid;
  logic       pkt_done;

  int errors = 0;
  int checks = 0;
  time t_par, t_hdr;

  always #5 clock = ~clock;

  router_pkt_tx dut (
    .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
    .payload_len(payload_len), .req_ready(req_ready), .cfg_err(cfg_err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
    .tx_data(tx_data), .pkt_valid(pkt_valid), .pkt_done(pkt_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic request(input logic [1:0] addr, input logic [5:0] len, input bit hold);
    start = 1'b1; dest_addr = addr; payload_len = len;
    @(negedge clock);
    if (!hold) start = 1'b0;
    check("req_pl_ready", pl_ready, 1);
    check("req_req_ready", req_ready, 0);
  endtask

  task automatic load_bytes(input int len, input logic [7:0] base, input int gap);
    for (int i = 0; i < len; i++) begin
      repeat (gap) begin
        pl_valid = 1'b0;
        @(negedge clock);
      end
      pl_valid = 1'b1;
      pl_data  = 8'(base + i);
      @(negedge clock);
    end
    pl_valid = 1'b0;
  endtask

  // Entered at the negedge where the header is first visible.
  task automatic stream_check(input logic [7:0] hdr, input int len, input logic [7:0] base,
                              input logic [7:0] par, input int busy_beat, input int busy_n,
                              output time tp);
    logic [7:0] exp_d;
    logic       exp_v;
    tp = 0;
    for (int k = 0; k <= len + 1; k++) begin
      exp_d = (k == 0) ? hdr : (k <= len) ? 8'(base + k - 1) : par;
      exp_v = (k <= len);
      check($sformatf("beat%0d_data", k), tx_data, exp_d);
      check($sformatf("beat%0d_valid", k), pkt_valid, exp_v);
      check($sformatf("beat%0d_done", k), pkt_done, 0);
      if (k == len + 1) tp = $time;
      if (k == busy_beat) begin
        busy = 1'b1;
        repeat (busy_n) begin
          @(negedge clock);
          check("busy_hold_data", tx_data, exp_d);
          check("busy_hold_valid", pkt_valid, exp_v);
        end
        busy = 1'b0;
      end
      @(negedge clock);
    end
    check("done_pulse", pkt_done, 1);
    check("done_tx_zero", tx_data, 0);
    check("done_valid", pkt_valid, 0);
    check("gap1_req_ready", req_ready, 0);
    @(negedge clock);
    check("done_one_cycle", pkt_done, 0);
    check("gap2_req_ready", req_ready, 0);
    check("gap2_valid", pkt_valid, 0);
    @(negedge clock);
    check("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
    #2;
    check("rst_tx_data", tx_data, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: addr 2, len 16, bytes 0x01..0x10 -> header 0x42, parity 0x52
    request(2'd2, 6'd16, 0);
    load_bytes(16, 8'h01, 0);
    stream_check(8'h42, 16, 8'h01, 8'h52, -1, 0, t_par);

    // 2: same packet with busy held 3 cycles on beat 0x05
    request(2'd2, 6'd16, 0);
    load_bytes(16, 8'h01, 0);
    stream_check(8'h42, 16, 8'h01, 8'h52, 5, 3, t_par);

    // 3: rejected requests
    start = 1'b1; dest_addr = 2'd3; payload_len = 6'd4;
    @(negedge clock);
    start = 1'b0;
    check("bad_addr_cfg_err", cfg_err, 1);
    check("bad_addr_req_ready", req_ready, 1);
    check("bad_addr_pl_ready", pl_ready, 0);
    check("bad_addr_valid", pkt_valid, 0);
    @(negedge clock);
    check("bad_addr_err_1cyc", cfg_err, 0);
    start = 1'b1; dest_addr = 2'd0; payload_len = 6'd0;
    @(negedge clock);
    start = 1'b0;
    check("bad_len_cfg_err", cfg_err, 1);
    check("bad_len_req_ready", req_ready, 1);
    check("bad_len_pl_ready", pl_ready, 0);
    check("bad_len_valid", pkt_valid, 0);
    @(negedge clock);
    check("bad_len_err_1cyc", cfg_err, 0);

    // 4: addr 0, len 1, byte 0xAA with pl_valid gaps -> 0x04, 0xAA, 0xAE
    request(2'd0, 6'd1, 0);
    load_bytes(1, 8'hAA, 3);
    stream_check(8'h04, 1, 8'hAA, 8'hAE, -1, 0, t_par);

    // 5: reset in PAYLOAD drops the packet immediately
    request(2'd2, 6'd16, 0);
    load_bytes(16, 8'h01, 0);
    repeat (2) @(negedge clock);
    check("pre_rst_valid", pkt_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", pkt_valid, 0);
    check("async_rst_tx", tx_data, 0);
    check("async_rst_req_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_ready", req_ready, 1);
    request(2'd2, 6'd16, 0);
    load_bytes(16, 8'h01, 0);
    stream_check(8'h42, 16, 8'h01, 8'h52, -1, 0, t_par);

    // 6: start held high; invalid fields during LOAD must be ignored
    request(2'd1, 6'd2, 1);
    dest_addr = 2'd3; payload_len = 6'd0;
    load_bytes(2, 8'h11, 0);
    check("b2b_ignore_err", cfg_err, 0);
    stream_check(8'h09, 2, 8'h11, 8'h0A, -1, 0, t_par);
    dest_addr = 2'd2; payload_len = 6'd1;
    @(negedge clock);
    start = 1'b0;
    check("b2b_accept", pl_ready, 1);
    check("b2b_no_err", cfg_err, 0);
    load_bytes(1, 8'h33, 0);
    t_hdr = $time;
    check("b2b_spacing", 32'((t_hdr - t_par) / 10), 5);
    stream_check(8'h06, 1, 8'h33, 8'h35, -1, 0, t_par);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
